// File: rtl/id_window_tracker_pkg.sv
// Shared types and default sizing for the in-order ID window tracker.
package id_window_tracker_pkg;

    localparam int LOG2_MAX_IDS = 3;
    localparam int MAX_IDS      = 1 << LOG2_MAX_IDS;
    localparam int RETIRE_PORTS = 2;

    typedef logic [LOG2_MAX_IDS-1:0] id_t;

endpackage

// File: rtl/id_done_bitmap.sv
// One done bit per ID: multi-port set (completions), multi-port clear (allocation),
// and independent read ports for the retire lookahead.
module id_done_bitmap #(
    parameter int NUM_IDS   = 8,
    parameter int SET_PORTS = 3,
    parameter int CLR_PORTS = 2,
    parameter int RD_PORTS  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_set_valid [SET_PORTS],
    input  logic [$clog2(NUM_IDS)-1:0] i_set_id    [SET_PORTS],
    input  logic                       i_clr_valid [CLR_PORTS],
    input  logic [$clog2(NUM_IDS)-1:0] i_clr_id    [CLR_PORTS],
    input  logic [$clog2(NUM_IDS)-1:0] i_rd_id     [RD_PORTS],
    output logic                       o_rd_done   [RD_PORTS]
);

    logic [NUM_IDS-1:0] r_done;
    logic [NUM_IDS-1:0] w_next;

    // Sets are applied after clears; the caller never aims both at the same ID.
    always_comb begin
        w_next = r_done;
        for (int c = 0; c < CLR_PORTS; c++) begin
            if (i_clr_valid[c]) w_next[i_clr_id[c]] = 1'b0;
        end
        for (int s = 0; s < SET_PORTS; s++) begin
            if (i_set_valid[s]) w_next[i_set_id[s]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= '0;
        else        r_done <= w_next;
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            o_rd_done[r] = r_done[i_rd_id[r]];
        end
    end

endmodule

// File: rtl/id_window_tracker.sv
// Circular window of in-flight IDs: allocates at tail, marks completions,
// retires in order from head, and supports rollback and flush squashes.
module id_window_tracker
    import id_window_tracker_pkg::*;
#(
    parameter int NUM_IDS      = MAX_IDS,
    parameter int ALLOC_WIDTH  = 2,
    parameter int RETIRE_WIDTH = RETIRE_PORTS,
    parameter int DONE_PORTS   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(ALLOC_WIDTH+1)-1:0]  alloc_req,
    output logic [$clog2(ALLOC_WIDTH+1)-1:0]  alloc_grant,
    output logic [$clog2(NUM_IDS)-1:0]        alloc_ids    [ALLOC_WIDTH],
    input  logic                              done_valid   [DONE_PORTS],
    input  logic [$clog2(NUM_IDS)-1:0]        done_id      [DONE_PORTS],
    input  logic                              rollback,
    input  logic [$clog2(NUM_IDS)-1:0]        rollback_id,
    input  logic                              flush,
    input  logic                              retire_hold,
    output logic                              retire_valid [RETIRE_WIDTH],
    output logic [$clog2(NUM_IDS)-1:0]        retire_ids   [RETIRE_WIDTH],
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
    output logic [$clog2(NUM_IDS):0]          inflight_count,
    output logic                              full,
    output logic                              empty
);

    localparam int IW  = $clog2(NUM_IDS);
    localparam int CW  = IW + 1;
    localparam int AGW = $clog2(ALLOC_WIDTH + 1);
    localparam int RCW = $clog2(RETIRE_WIDTH + 1);

    logic [IW-1:0]  r_head;
    logic [IW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic           r_ret_valid [RETIRE_WIDTH];
    logic [IW-1:0]  r_ret_ids   [RETIRE_WIDTH];
    logic [RCW-1:0] r_ret_count;

    logic [AGW-1:0] w_grant;
    int             w_free;
    int             w_grant_int;
    logic           w_clr_valid [ALLOC_WIDTH];
    logic [IW-1:0]  w_clr_id    [ALLOC_WIDTH];
    logic [IW-1:0]  w_done_off  [DONE_PORTS];
    logic           w_done_in   [DONE_PORTS];
    logic [IW-1:0]  w_rb_off;
    logic [CW-1:0]  w_rb_len;
    logic [CW-1:0]  w_live;
    logic [IW-1:0]  w_rd_id     [RETIRE_WIDTH];
    logic           w_rd_done   [RETIRE_WIDTH];
    logic           w_ret_ok    [RETIRE_WIDTH];
    logic           w_chain;
    logic [RCW-1:0] w_ret_n;

    always_comb begin
        w_free      = NUM_IDS - int'(r_count);
        w_grant_int = int'(alloc_req);
        if (w_grant_int > w_free)      w_grant_int = w_free;
        if (w_grant_int > ALLOC_WIDTH) w_grant_int = ALLOC_WIDTH;
        if (rollback || flush || !rst_n) w_grant_int = 0;
        w_grant = AGW'(w_grant_int);
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_clr_id[i]    = r_tail + IW'(i);
            w_clr_valid[i] = (i < w_grant_int);
        end
    end

    // Completions count only for IDs currently between head and tail.
    always_comb begin
        for (int p = 0; p < DONE_PORTS; p++) begin
            w_done_off[p] = done_id[p] - r_head;
            w_done_in[p]  = done_valid[p] && ({1'b0, w_done_off[p]} < r_count);
        end
    end

    // On rollback only IDs up to rollback_id survive, so none younger may retire.
    always_comb begin
        w_rb_off = rollback_id - r_head;
        w_rb_len = {1'b0, w_rb_off} + CW'(1);
        w_live   = (rollback && !flush) ? w_rb_len : r_count;
        w_chain  = !retire_hold && !flush;
        w_ret_n  = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            w_rd_id[i]  = r_head + IW'(i);
            w_chain     = w_chain && (i < int'(w_live)) && w_rd_done[i];
            w_ret_ok[i] = w_chain;
            if (w_chain) w_ret_n = w_ret_n + RCW'(1);
        end
    end

    id_done_bitmap #(
        .NUM_IDS   (NUM_IDS),
        .SET_PORTS (DONE_PORTS),
        .CLR_PORTS (ALLOC_WIDTH),
        .RD_PORTS  (RETIRE_WIDTH)
    ) u_done_bitmap (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_valid (w_done_in),
        .i_set_id    (done_id),
        .i_clr_valid (w_clr_valid),
        .i_clr_id    (w_clr_id),
        .i_rd_id     (w_rd_id),
        .o_rd_done   (w_rd_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ret_count <= '0;
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                r_ret_valid[i] <= 1'b0;
                r_ret_ids[i]   <= IW'(i);
            end
        end else begin
            r_head      <= r_head + IW'(w_ret_n);
            r_ret_count <= w_ret_n;
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                r_ret_valid[i] <= w_ret_ok[i];
                r_ret_ids[i]   <= w_rd_id[i];
            end
            if (flush) begin
                r_tail  <= r_head;
                r_count <= '0;
            end else if (rollback) begin
                r_tail  <= rollback_id + IW'(1);
                r_count <= w_rb_len - CW'(w_ret_n);
            end else begin
                r_tail  <= r_tail + IW'(w_grant);
                r_count <= r_count + CW'(w_grant) - CW'(w_ret_n);
            end
        end
    end

    always_comb begin
        alloc_grant = w_grant;
        for (int i = 0; i < ALLOC_WIDTH; i++) alloc_ids[i] = w_clr_id[i];
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            retire_valid[i] = r_ret_valid[i];
            retire_ids[i]   = r_ret_ids[i];
        end
        retire_count   = r_ret_count;
        inflight_count = r_count;
        full           = (r_count == CW'(NUM_IDS));
        empty          = (r_count == '0);
    end

    for (genvar p = 0; p < DONE_PORTS; p++) begin : g_done_chk
        a_done_allocated: assert property (@(posedge clk) disable iff (!rst_n)
            done_valid[p] |-> w_done_in[p]);
    end

    a_rollback_in_window: assert property (@(posedge clk) disable iff (!rst_n)
        (rollback && !flush) |-> ({1'b0, w_rb_off} < r_count));

    a_grant_fits: assert property (@(posedge clk) disable iff (!rst_n)
        CW'(alloc_grant) <= CW'(NUM_IDS) - r_count);

endmodule

// File: tb/tb_id_window_tracker.sv
// Bench for id_window_tracker: directed scenarios plus random traffic against a
// queue-based model of the live ID window.
module tb_id_window_tracker;
    import id_window_tracker_pkg::*;

    localparam int N  = 8;
    localparam int AW = 2;
    localparam int RW = 2;
    localparam int DP = 3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alloc_req;
    logic [1:0]  alloc_grant;
    logic [2:0]  alloc_ids    [AW];
    logic        done_valid   [DP];
    logic [2:0]  done_id      [DP];
    logic        rollback;
    logic [2:0]  rollback_id;
    logic        flush;
    logic        retire_hold;
    logic        retire_valid [RW];
    logic [2:0]  retire_ids   [RW];
    logic [1:0]  retire_count;
    logic [3:0]  inflight_count;
    logic        full;
    logic        empty;

    // Reference model: live IDs oldest-first, a done flag per ID, and the next free ID.
    id_t exp_q[$];
    bit  m_done [N];
    int  m_tail;

    int tests;
    int fails;

    id_window_tracker #(
        .NUM_IDS      (N),
        .ALLOC_WIDTH  (AW),
        .RETIRE_WIDTH (RW),
        .DONE_PORTS   (DP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_req      (alloc_req),
        .alloc_grant    (alloc_grant),
        .alloc_ids      (alloc_ids),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .rollback       (rollback),
        .rollback_id    (rollback_id),
        .flush          (flush),
        .retire_hold    (retire_hold),
        .retire_valid   (retire_valid),
        .retire_ids     (retire_ids),
        .retire_count   (retire_count),
        .inflight_count (inflight_count),
        .full           (full),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_live(input int id);
        foreach (exp_q[k]) if (int'(exp_q[k]) == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        alloc_req   = 2'd0;
        rollback    = 1'b0;
        rollback_id = 3'd0;
        flush       = 1'b0;
        retire_hold = 1'b0;
        for (int p = 0; p < DP; p++) begin
            done_valid[p] = 1'b0;
            done_id[p]    = 3'd0;
        end
    endtask

    task automatic set_done(input int p, input int id);
        done_valid[p] = 1'b1;
        done_id[p]    = id[2:0];
    endtask

    // Reset asserted mid-cycle; registered outputs must clear without a clock edge.
    task automatic do_reset();
        idle_inputs();
        alloc_req = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_grant", int'(alloc_grant), 0);
        check_eq("rst_inflight", int'(inflight_count), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_retire_count", int'(retire_count), 0);
        for (int i = 0; i < RW; i++) begin
            check_eq("rst_retire_valid", int'(retire_valid[i]), 0);
            check_eq("rst_retire_id", int'(retire_ids[i]), i);
        end
        exp_q.delete();
        foreach (m_done[i]) m_done[i] = 1'b0;
        m_tail = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        alloc_req = 2'd0;
        @(posedge clk);
        #1;
    endtask

    // One clock: check combinational grant, advance the model at the edge, check registered outputs.
    task automatic cycle();
        int  g;
        int  win;
        int  rb_idx;
        int  n;
        bit  chain;
        bit  rv [RW];
        int  rid [RW];
        @(negedge clk);
        g = int'(alloc_req);
        if (g > N - exp_q.size()) g = N - exp_q.size();
        if (g > AW) g = AW;
        if (rollback || flush) g = 0;
        check_eq("alloc_grant", int'(alloc_grant), g);
        for (int i = 0; i < g; i++) check_eq("alloc_id", int'(alloc_ids[i]), (m_tail + i) % N);

        win    = exp_q.size();
        rb_idx = -1;
        if (rollback && !flush) begin
            foreach (exp_q[k]) if (exp_q[k] == rollback_id) rb_idx = k;
            win = rb_idx + 1;
        end
        n     = 0;
        chain = !retire_hold && !flush;
        for (int i = 0; i < RW; i++) begin
            rid[i] = 0;
            if (chain && i < win) begin
                rid[i] = int'(exp_q[i]);
                chain  = m_done[rid[i]];
            end else begin
                chain = 1'b0;
            end
            rv[i] = chain;
            if (chain) n++;
        end

        @(posedge clk);
        for (int p = 0; p < DP; p++) begin
            if (done_valid[p] && is_live(int'(done_id[p]))) m_done[done_id[p]] = 1'b1;
        end
        if (flush) begin
            if (exp_q.size() > 0) m_tail = int'(exp_q[0]);
            exp_q.delete();
        end else if (rb_idx >= 0) begin
            while (exp_q.size() > rb_idx + 1) void'(exp_q.pop_back());
            m_tail = (int'(rollback_id) + 1) % N;
        end else begin
            for (int i = 0; i < g; i++) begin
                exp_q.push_back(id_t'((m_tail + i) % N));
                m_done[(m_tail + i) % N] = 1'b0;
            end
            m_tail = (m_tail + g) % N;
        end
        repeat (n) void'(exp_q.pop_front());

        #1;
        check_eq("retire_count", int'(retire_count), n);
        for (int i = 0; i < RW; i++) begin
            check_eq("retire_valid", int'(retire_valid[i]), int'(rv[i]));
            if (rv[i]) check_eq("retire_id", int'(retire_ids[i]), rid[i]);
        end
        check_eq("inflight", int'(inflight_count), exp_q.size());
        check_eq("full", int'(full), int'(exp_q.size() == N));
        check_eq("empty", int'(empty), int'(exp_q.size() == 0));
    endtask

    task automatic alloc_cycles(input int k);
        for (int c = 0; c < k; c++) begin
            idle_inputs();
            alloc_req = 2'd2;
            cycle();
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int c = 0; c < k; c++) begin
            idle_inputs();
            cycle();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        idle_inputs();

        // Fill the window completely, then ask for more.
        do_reset();
        alloc_cycles(4);
        check_eq("fill_full", int'(full), 1);
        check_eq("fill_inflight", int'(inflight_count), 8);
        alloc_cycles(1);

        // Out-of-order completion, in-order retirement.
        do_reset();
        alloc_cycles(2);
        idle_inputs(); set_done(0, 1); cycle();
        idle_inputs(); set_done(0, 0); cycle();
        idle_cycles(1);
        check_eq("ooo_ret0", int'(retire_ids[0]), 0);
        check_eq("ooo_ret1", int'(retire_ids[1]), 1);
        check_eq("ooo_inflight", int'(inflight_count), 2);
        idle_cycles(1);

        // Rollback squashes younger IDs; reallocated IDs start not-done.
        do_reset();
        alloc_cycles(3);
        idle_inputs(); set_done(0, 3); set_done(1, 4); cycle();
        idle_inputs(); rollback = 1'b1; rollback_id = 3'd2; cycle();
        check_eq("rb_inflight", int'(inflight_count), 3);
        alloc_cycles(1);
        idle_inputs(); set_done(0, 0); set_done(1, 1); set_done(2, 2); cycle();
        idle_cycles(4);
        check_eq("rb_left", int'(inflight_count), 2);

        // Wrap-around retirement gated by retire_hold.
        do_reset();
        alloc_cycles(3);
        idle_inputs(); set_done(0, 0); set_done(1, 1); set_done(2, 2); cycle();
        idle_inputs(); set_done(0, 3); set_done(1, 4); set_done(2, 5); cycle();
        idle_cycles(4);
        alloc_cycles(2);
        idle_inputs(); retire_hold = 1'b1; set_done(0, 6); set_done(1, 7); set_done(2, 0); cycle();
        idle_inputs(); retire_hold = 1'b1; set_done(0, 1); cycle();
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            retire_hold = (k % 2 == 0);
            cycle();
        end
        check_eq("wrap_empty", int'(empty), 1);

        // Flush beats rollback, done and allocation in the same cycle.
        do_reset();
        alloc_cycles(2);
        idle_inputs(); retire_hold = 1'b1; set_done(0, 0); set_done(1, 1); set_done(2, 2); cycle();
        idle_inputs(); retire_hold = 1'b1; cycle();
        idle_inputs();
        flush = 1'b1; rollback = 1'b1; rollback_id = 3'd1; set_done(0, 3); alloc_req = 2'd2;
        cycle();
        check_eq("flush_inflight", int'(inflight_count), 0);
        check_eq("flush_no_retire", int'(retire_valid[0]), 0);
        idle_cycles(1);
        alloc_cycles(1);
        idle_cycles(1);

        // Reset while retirement is in progress.
        do_reset();
        alloc_cycles(2);
        idle_inputs(); set_done(0, 0); set_done(1, 1); set_done(2, 2); cycle();
        idle_cycles(1);
        check_eq("pre_rst_retiring", int'(retire_valid[0]), 1);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            alloc_req   = 2'($urandom_range(0, 2));
            retire_hold = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < DP; p++) begin
                if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
                    set_done(p, int'(exp_q[$urandom_range(0, exp_q.size() - 1)]));
            end
            if (exp_q.size() > 0 && $urandom_range(0, 15) == 0) begin
                rollback    = 1'b1;
                rollback_id = exp_q[$urandom_range(0, exp_q.size() - 1)];
            end
            if ($urandom_range(0, 31) == 0) flush = 1'b1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
